// File: rtl/csr_responder_pkg.sv
// Shared definitions for the CSR responder: CTRL bit positions, address-region
// decode helpers and the launch state encoding.
package csr_responder_pkg;

  localparam int unsigned CtrlStartBit      = 0;  // write side of CTRL
  localparam int unsigned CtrlCfgPendingBit = 0;  // read side of CTRL
  localparam int unsigned CtrlBusyBit       = 1;

  typedef enum logic [1:0] {
    RegionRw,
    RegionCtrl,
    RegionStatus,
    RegionUnmapped
  } region_e;

  typedef enum logic {
    CfgIdle,
    CfgPending
  } cfg_state_e;

  function automatic int unsigned ctrl_addr(input int unsigned num_rw);
    return num_rw;
  endfunction

  function automatic int unsigned status_base(input int unsigned num_rw);
    return num_rw + 1;
  endfunction

  function automatic region_e decode_region(input int unsigned addr,
                                            input int unsigned num_rw,
                                            input int unsigned num_ro);
    if (addr < num_rw) return RegionRw;
    if (addr == ctrl_addr(num_rw)) return RegionCtrl;
    if (addr < status_base(num_rw) + num_ro) return RegionStatus;
    return RegionUnmapped;
  endfunction

endpackage

// File: rtl/csr_responder_if.sv
// CSR request/response bus: valid/ready request channel plus valid/ready
// read-response channel.
interface csr_responder_if #(
  parameter int unsigned AddrWidth = 3,
  parameter int unsigned DataWidth = 32
) ();

  logic [AddrWidth-1:0] csr_addr_i;
  logic [DataWidth-1:0] csr_wr_data_i;
  logic                 csr_wr_en_i;
  logic                 csr_req_valid_i;
  logic                 csr_req_ready_o;
  logic [DataWidth-1:0] csr_rd_data_o;
  logic                 csr_rsp_valid_o;
  logic                 csr_rsp_ready_i;

  modport master (
    output csr_addr_i, csr_wr_data_i, csr_wr_en_i, csr_req_valid_i, csr_rsp_ready_i,
    input  csr_req_ready_o, csr_rd_data_o, csr_rsp_valid_o
  );

  modport slave (
    input  csr_addr_i, csr_wr_data_i, csr_wr_en_i, csr_req_valid_i, csr_rsp_ready_i,
    output csr_req_ready_o, csr_rd_data_o, csr_rsp_valid_o
  );

endinterface

// File: rtl/csr_rsp_buffer.sv
// One-entry valid/ready register slice for read responses; supports a load and
// an unload in the same cycle so back-to-back reads run at full rate.
module csr_rsp_buffer #(
  parameter int unsigned DataWidth = 32
) (
  input  logic                 clk_i,
  input  logic                 rst_ni,
  input  logic                 in_valid_i,
  output logic                 in_ready_o,
  input  logic [DataWidth-1:0] in_data_i,
  output logic                 out_valid_o,
  input  logic                 out_ready_i,
  output logic [DataWidth-1:0] out_data_o
);

  logic                 valid_q, valid_d;
  logic [DataWidth-1:0] data_q, data_d;

  assign in_ready_o  = !valid_q || out_ready_i;
  assign out_valid_o = valid_q;
  assign out_data_o  = data_q;

  // NOTE: defaults first so every path assigns valid_d/data_d; no latch inferred.
  always_comb begin
    valid_d = valid_q;
    data_d  = data_q;
    if (in_valid_i && in_ready_o) begin
      valid_d = 1'b1;
      data_d  = in_data_i;
    end else if (out_ready_i) begin
      valid_d = 1'b0;
    end
  end

  // NOTE: non-blocking assignments here so all flops update from pre-edge values.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      valid_q <= 1'b0;
      data_q  <= '0;
    end else begin
      valid_q <= valid_d;
      data_q  <= data_d;
    end
  end

endmodule

// File: rtl/csr_responder.sv
// CSR responder: RW shadow registers, a CTRL register that launches a
// configuration snapshot to the accelerator, and read-only status words.
module csr_responder
  import csr_responder_pkg::*;
#(
  parameter int unsigned NumRwCsr     = 4,
  parameter int unsigned NumRoCsr     = 2,
  parameter int unsigned RegDataWidth = 32,
  parameter int unsigned RegAddrWidth = $clog2(NumRwCsr + 1 + NumRoCsr)
) (
  input  logic                                   clk_i,
  input  logic                                   rst_ni,
  csr_responder_if.slave                         csr_bus,
  output logic [NumRwCsr-1:0][RegDataWidth-1:0]  cfg_o,
  output logic                                   cfg_valid_o,
  input  logic                                   cfg_ready_i,
  input  logic                                   acc_busy_i,
  input  logic [NumRoCsr-1:0][RegDataWidth-1:0]  status_i
);

  localparam int unsigned RwIdxW = (NumRwCsr > 1) ? $clog2(NumRwCsr) : 1;
  localparam int unsigned StIdxW = (NumRoCsr > 1) ? $clog2(NumRoCsr) : 1;

  typedef logic [NumRwCsr-1:0][RegDataWidth-1:0] reg_bank_t;

  region_e                 region;
  logic [RwIdxW-1:0]       rw_idx;
  logic [StIdxW-1:0]       st_idx;
  logic                    launch_req;
  logic                    buf_in_ready;
  logic                    req_accept;
  logic                    rd_accept;
  logic                    rw_write;
  logic                    launch_accept;
  logic [RegDataWidth-1:0] rd_data;

  reg_bank_t  shadow_q, shadow_d;
  reg_bank_t  cfg_q, cfg_d;
  cfg_state_e cfg_state_q, cfg_state_d;

  // ---------------------------------------------------------------------------
  // Request decode and handshake
  // ---------------------------------------------------------------------------
  assign region = decode_region(32'(csr_bus.csr_addr_i), NumRwCsr, NumRoCsr);
  assign rw_idx = RwIdxW'(csr_bus.csr_addr_i);
  assign st_idx = StIdxW'(csr_bus.csr_addr_i - RegAddrWidth'(status_base(NumRwCsr)));

  assign launch_req = csr_bus.csr_wr_en_i && (region == RegionCtrl)
                   && csr_bus.csr_wr_data_i[CtrlStartBit];

  // Ready never looks at valid: a full response slot or a launch that would
  // overwrite an unconsumed snapshot holds the request off.
  assign csr_bus.csr_req_ready_o = buf_in_ready && !(launch_req && cfg_valid_o);

  assign req_accept    = csr_bus.csr_req_valid_i && csr_bus.csr_req_ready_o;
  assign rd_accept     = req_accept && !csr_bus.csr_wr_en_i;
  assign rw_write      = req_accept && csr_bus.csr_wr_en_i && (region == RegionRw);
  assign launch_accept = req_accept && launch_req;

  // ---------------------------------------------------------------------------
  // Read data, sampled in the acceptance cycle
  // ---------------------------------------------------------------------------
  always_comb begin
    rd_data = '0;
    unique case (region)
      RegionRw:     rd_data = shadow_q[rw_idx];
      RegionCtrl: begin
        rd_data[CtrlBusyBit]       = acc_busy_i;
        rd_data[CtrlCfgPendingBit] = cfg_valid_o;
      end
      RegionStatus: rd_data = status_i[st_idx];
      default:      rd_data = '0;
    endcase
  end

  csr_rsp_buffer #(
    .DataWidth (RegDataWidth)
  ) u_rsp_buffer (
    .clk_i       (clk_i),
    .rst_ni      (rst_ni),
    .in_valid_i  (rd_accept),
    .in_ready_o  (buf_in_ready),
    .in_data_i   (rd_data),
    .out_valid_o (csr_bus.csr_rsp_valid_o),
    .out_ready_i (csr_bus.csr_rsp_ready_i),
    .out_data_o  (csr_bus.csr_rd_data_o)
  );

  // ---------------------------------------------------------------------------
  // Shadow registers
  // ---------------------------------------------------------------------------
  always_comb begin
    shadow_d = shadow_q;
    if (rw_write) shadow_d[rw_idx] = csr_bus.csr_wr_data_i;
  end

  // NOTE: the register bank is reset explicitly because reads after reset must
  // return zero; large storage without that need would be left unreset.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) shadow_q <= '0;
    else         shadow_q <= shadow_d;
  end

  // ---------------------------------------------------------------------------
  // Launch FSM: snapshot held stable until the accelerator takes it
  // ---------------------------------------------------------------------------
  always_comb begin
    cfg_state_d = cfg_state_q;
    cfg_d       = cfg_q;
    unique case (cfg_state_q)
      CfgIdle: begin
        if (launch_accept) begin
          cfg_state_d = CfgPending;
          cfg_d       = shadow_q;
        end
      end
      CfgPending: begin
        if (cfg_ready_i) cfg_state_d = CfgIdle;
      end
      default: cfg_state_d = CfgIdle;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      cfg_state_q <= CfgIdle;
      cfg_q       <= '0;
    end else begin
      cfg_state_q <= cfg_state_d;
      cfg_q       <= cfg_d;
    end
  end

  assign cfg_valid_o = (cfg_state_q == CfgPending);
  assign cfg_o       = cfg_q;

endmodule

// File: doc/csr_responder.md
CSR_RESPONDER -- requirements
Module: csr_responder

Interface
REQ-001 Parameter NumRwCsr, default 4, number of read-write configuration CSRs.
REQ-002 Parameter NumRoCsr, default 2, number of read-only status CSRs.
REQ-003 Parameter RegDataWidth, default 32, CSR data width.
REQ-004 Parameter RegAddrWidth, default $clog2(NumRwCsr+1+NumRoCsr), CSR address width.
REQ-005 The block SHALL have one clock and an asynchronous, active-low reset.
REQ-006 clk_i  in  1  sole clock, rising edge.
REQ-007 rst_ni  in  1  asynchronous active-low reset.
REQ-008 csr_addr_i  in  RegAddrWidth  request address.
REQ-009 csr_wr_data_i  in  RegDataWidth  write data.
REQ-010 csr_wr_en_i  in  1  1 = write, 0 = read.
REQ-011 csr_req_valid_i / csr_req_ready_o  in/out  1  request handshake.
REQ-012 csr_rd_data_o  out  RegDataWidth  read response data.
REQ-013 csr_rsp_valid_o / csr_rsp_ready_i  out/in  1  response handshake.
REQ-014 cfg_o  out  NumRwCsr x RegDataWidth  launched configuration snapshot.
REQ-015 cfg_valid_o / cfg_ready_i  out/in  1  launch handshake to accelerator.
REQ-016 acc_busy_i  in  1  accelerator running.
REQ-017 status_i  in  NumRoCsr x RegDataWidth  accelerator status words.

Function
REQ-018 Address map SHALL be: 0..NumRwCsr-1 RW shadow regs; NumRwCsr = CTRL; NumRwCsr+1..NumRwCsr+NumRoCsr = status_i[addr-NumRwCsr-1]; higher = unmapped.
REQ-019 A request SHALL be accepted when csr_req_valid_i and csr_req_ready_o are both high at a rising edge.
REQ-020 Accepted write to RW reg SHALL update that shadow reg next edge; cfg_o SHALL NOT change.
REQ-021 Accepted write to CTRL with wr_data[0]=1 SHALL copy all shadow regs to cfg_o and set cfg_valid_o next edge; wr_data[0]=0 SHALL have no effect.
REQ-022 cfg_valid_o SHALL clear on the edge where cfg_valid_o and cfg_ready_i are both high; cfg_o SHALL hold stable while cfg_valid_o is high.
REQ-023 Writes SHALL produce no response; writes to unmapped or status addresses SHALL be silently dropped.
REQ-024 Accepted read SHALL raise csr_rsp_valid_o on the next edge (1-cycle latency) with registered data; unmapped reads return 0.
REQ-025 CTRL read data SHALL be {0..., acc_busy_i, cfg_valid_o} sampled at acceptance; status reads sample status_i at acceptance.
REQ-026 csr_rd_data_o SHALL be stable while csr_rsp_valid_o is high and csr_rsp_ready_i is low.
REQ-027 One-entry response buffer: csr_req_ready_o SHALL be low when csr_rsp_valid_o is high and csr_rsp_ready_i is low.
REQ-028 csr_req_ready_o SHALL also be low for a CTRL launch write (wr_data[0]=1) while cfg_valid_o is high.
REQ-029 Response consumed and new read accepted in same cycle SHALL keep csr_rsp_valid_o high with new data next edge (full throughput).
REQ-030 csr_req_ready_o SHALL be combinational from state and csr_rsp_ready_i/request fields only, never from csr_req_valid_i.

Reset
REQ-031 On rst_ni low: shadow regs, cfg_o, csr_rd_data_o = 0; cfg_valid_o, csr_rsp_valid_o = 0, immediately and asynchronously.
REQ-032 Reset mid-transaction SHALL discard any pending response and launch; no handshake completes during reset.

Structure
REQ-033 Package csr_responder_pkg SHALL hold CTRL bit positions (START=0, CFG_PENDING=0, BUSY=1) and address-region offset helpers.
REQ-034 One sub-module csr_rsp_buffer (one-entry valid/ready data register) SHALL implement the response path.

Verification
REQ-035 Write 0xA5 to addr 1, read addr 1 -> rsp_valid one cycle after acceptance, rd_data=0xA5; cfg_o[1] still 0.
REQ-036 Write regs 0..3 = 1,2,3,4, write CTRL=1, cfg_ready_i low 5 cycles -> cfg_valid_o high, cfg_o={1,2,3,4} stable; second CTRL=1 stalls until cfg_ready_i=1.
REQ-037 Read with csr_rsp_ready_i low 3 cycles -> csr_req_ready_o low, rd_data stable; ready high -> next read accepted same cycle.
REQ-038 status_i[1]=0xDEAD, read addr NumRwCsr+2 -> 0xDEAD; read addr 7 -> 0; write addr 6 -> no change, no response.
REQ-039 Assert rst_ni low with rsp_valid and cfg_valid high -> both 0 immediately; all reads after reset return 0.
